// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register file geometry, flag register index
// and the opcode classes decoded in OF.
package pipe_pkg;

  localparam int NREGS = 16;
  localparam int IDXW  = 4;
  localparam logic [IDXW-1:0] FLAG_REG = 4'd15;

  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_MEM    = 2'd1,
    OPC_BRANCH = 2'd2,
    OPC_SYS    = 2'd3
  } opc_class_e;

endpackage

// File: rtl/sb_counter.sv
// One saturating up/down pending-write counter. A decrement of up to 2
// covers a squash and a writeback landing on the same register.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [1:0]    dec,
  output logic [CW-1:0] count,
  output logic          underflow
);

  logic [CW-1:0] count_r;
  logic [CW-1:0] next_s;
  logic [CW+1:0] sum_s;
  logic [CW+1:0] diff_s;
  logic [CW-1:0] max_s;

  // Next count: apply increment first so inc+dec on one edge cancels cleanly
  always_comb begin
    max_s     = {CW{1'b1}};
    sum_s     = {2'b00, count_r} + {{(CW+1){1'b0}}, inc};
    diff_s    = sum_s - {{CW{1'b0}}, dec};
    underflow = 1'b0;
    next_s    = count_r;
    if (sum_s < {{CW{1'b0}}, dec}) begin
      underflow = 1'b1;
      next_s    = {CW{1'b0}};
    end else if (diff_s > {2'b00, max_s}) begin
      next_s = max_s;
    end else begin
      next_s = diff_s[CW-1:0];
    end
  end

  // Counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= next_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the OF stage: tracks in-flight writes per register,
// stalls readers of pending registers and squashes the EX slot on flush.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREGS = pipe_pkg::NREGS,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_writes,
  input  logic [3:0]       issue_dest,
  input  logic             use_src1,
  input  logic             use_src2,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             use_flags,
  input  logic             wb_valid,
  input  logic [3:0]       wb_dest,
  input  logic             flush,
  output logic             stall,
  output logic             issue_accept,
  output logic [NREGS-1:0] pending_mask,
  output logic [15:0]      stall_count,
  output logic             wb_error
);

  logic             stall_s;
  logic             accept_s;
  logic             tag_valid_r;
  logic [IDXW-1:0]  tag_dest_r;
  logic [NREGS-1:0] pend_s;
  logic [NREGS-1:0] uflow_s;
  logic [15:0]      stall_count_r;
  logic             wb_error_r;

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : g_reg
      logic          inc_s;
      logic          wb_hit_s;
      logic          sq_hit_s;
      logic [1:0]    dec_s;
      logic [CW-1:0] count_s;

      assign inc_s    = accept_s && issue_writes && (issue_dest == IDXW'(r));
      assign wb_hit_s = wb_valid && (wb_dest == IDXW'(r));
      assign sq_hit_s = flush && tag_valid_r && (tag_dest_r == IDXW'(r));
      assign dec_s    = {1'b0, wb_hit_s} + {1'b0, sq_hit_s};

      sb_counter #(.CW(CW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_s),
        .dec       (dec_s),
        .count     (count_s),
        .underflow (uflow_s[r])
      );

      assign pend_s[r] = |count_s;
    end
  endgenerate

  // Hazard detect: no bypass, so a writeback this cycle does not release the stall
  always_comb begin
    stall_s = 1'b0;
    if (issue_valid && !flush) begin
      stall_s = (use_src1  && pend_s[src1]) ||
                (use_src2  && pend_s[src2]) ||
                (use_flags && pend_s[FLAG_REG]);
    end else begin
      stall_s = 1'b0;
    end
  end

  assign accept_s = issue_valid && !stall_s && !flush;

  // EX slot tag; a flush never accepts, so the squashed entry clears itself
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_r <= 1'b0;
      tag_dest_r  <= {IDXW{1'b0}};
    end else begin
      tag_valid_r <= accept_s && issue_writes;
      tag_dest_r  <= issue_dest;
    end
  end

  // Stall statistics and sticky writeback error
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= 16'h0000;
      wb_error_r    <= 1'b0;
    end else begin
      if (stall_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'h0001;
      end else begin
        stall_count_r <= stall_count_r;
      end
      wb_error_r <= wb_error_r || (|uflow_s);
    end
  end

  assign stall        = stall_s;
  assign issue_accept = accept_s;
  assign pending_mask = pend_s;
  assign stall_count  = stall_count_r;
  assign wb_error     = wb_error_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-register pending-count model is
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_reg_scoreboard;

  localparam int MAXC = 3;

  logic        clk;
  logic        rst;
  logic        issue_valid, issue_writes;
  logic [3:0]  issue_dest;
  logic        use_src1, use_src2;
  logic [3:0]  src1, src2;
  logic        use_flags;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        flush;
  logic        stall, issue_accept;
  logic [15:0] pending_mask;
  logic [15:0] stall_count;
  logic        wb_error;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int m_cnt [16];
  bit m_tagv;
  int m_tagd;
  int m_sc;
  bit m_err;

  reg_scoreboard #(.NREGS(16), .CW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .use_src1     (use_src1),
    .use_src2     (use_src2),
    .src1         (src1),
    .src2         (src2),
    .use_flags    (use_flags),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .flush        (flush),
    .stall        (stall),
    .issue_accept (issue_accept),
    .pending_mask (pending_mask),
    .stall_count  (stall_count),
    .wb_error     (wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    if (!issue_valid || flush) return 1'b0;
    return (use_src1 && m_cnt[src1] > 0) || (use_src2 && m_cnt[src2] > 0) ||
           (use_flags && m_cnt[15] > 0);
  endfunction

  // Model state update at each rising edge
  always @(posedge clk) begin
    int  tmp [16];
    bit  st, acc, err;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_cnt[i] <= 0;
      m_tagv <= 1'b0;
      m_tagd <= 0;
      m_sc   <= 0;
      m_err  <= 1'b0;
    end else begin
      st  = m_stall();
      acc = issue_valid && !st && !flush;
      for (int i = 0; i < 16; i++) tmp[i] = m_cnt[i];
      if (acc && issue_writes) tmp[issue_dest] = tmp[issue_dest] + 1;
      if (wb_valid) tmp[wb_dest] = tmp[wb_dest] - 1;
      if (flush && m_tagv) tmp[m_tagd] = tmp[m_tagd] - 1;
      err = m_err;
      for (int i = 0; i < 16; i++) begin
        if (tmp[i] < 0) begin
          tmp[i] = 0;
          err = 1'b1;
        end else if (tmp[i] > MAXC) begin
          tmp[i] = MAXC;
        end
        m_cnt[i] <= tmp[i];
      end
      m_err  <= err;
      m_tagv <= acc && issue_writes;
      m_tagd <= int'(issue_dest);
      m_sc   <= (st && m_sc < 65535) ? m_sc + 1 : m_sc;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [15:0] em;
    bit st;
    if (chk_en) begin
      st = m_stall();
      for (int i = 0; i < 16; i++) em[i] = (m_cnt[i] != 0);
      check("cyc_stall", stall, st);
      check("cyc_accept", issue_accept, issue_valid && !st && !flush);
      check("cyc_mask", pending_mask, em);
      check("cyc_stall_count", stall_count, m_sc);
      check("cyc_wb_error", wb_error, m_err);
    end
  end

  task automatic idle();
    issue_valid = 1'b0; issue_writes = 1'b0; issue_dest = 4'd0;
    use_src1 = 1'b0; use_src2 = 1'b0; src1 = 4'd0; src2 = 4'd0;
    use_flags = 1'b0; wb_valid = 1'b0; wb_dest = 4'd0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] d);
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = d;
  endtask

  task automatic rd(input logic [3:0] s);
    issue_valid = 1'b1; use_src1 = 1'b1; src1 = s;
  endtask

  task automatic wb(input logic [3:0] d);
    wb_valid = 1'b1; wb_dest = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mask", pending_mask, 16'h0000);
    check("rst_stall_count", stall_count, 16'h0000);
    check("rst_wb_error", wb_error, 1'b0);
    issue_valid = 1'b1; #1;
    check("rst_accept_follows", issue_accept, 1'b1);
    tick();

    // write R3, then a reader stalls 3 cycles and goes once wb commits
    wr(4'd3); #1; check("r3_wr_accept", issue_accept, 1'b1); tick();
    rd(4'd3); #1; check("r3_stall1", stall, 1'b1); check("r3_mask", pending_mask, 16'h0008); tick();
    rd(4'd3); #1; check("r3_stall2", stall, 1'b1); tick();
    rd(4'd3); wb(4'd3); #1; check("r3_stall3_nobypass", stall, 1'b1); tick();
    rd(4'd3); #1; check("r3_accept", issue_accept, 1'b1); check("r3_stall_count", stall_count, 16'd3); tick();

    // two writes to R5, mask held until the second writeback
    wr(4'd5); tick();
    wr(4'd5); tick();
    wb(4'd5); tick();
    #1; check("r5_after_wb1", pending_mask[5], 1'b1);
    wb(4'd5); tick();
    #1; check("r5_after_wb2", pending_mask, 16'h0000);

    // write R7 squashed by flush
    wr(4'd7); tick();
    flush = 1'b1; #1; check("r7_pending", pending_mask, 16'h0080); tick();
    rd(4'd7); #1; check("r7_no_stall", stall, 1'b0); check("r7_mask", pending_mask, 16'h0000); tick();

    // flag register dependency
    wr(4'd15); tick();
    issue_valid = 1'b1; use_flags = 1'b1; #1; check("r15_stall1", stall, 1'b1); tick();
    issue_valid = 1'b1; use_flags = 1'b1; wb(4'd15); #1; check("r15_stall2", stall, 1'b1); tick();
    issue_valid = 1'b1; use_flags = 1'b1; #1; check("r15_accept", issue_accept, 1'b1); tick();

    // same-edge increment and decrement cancel
    wr(4'd2); tick();
    wr(4'd2); wb(4'd2); tick();
    #1; check("r2_unchanged", pending_mask, 16'h0004);
    wb(4'd2); tick();
    #1; check("r2_cleared", pending_mask, 16'h0000);

    // squash plus writeback on the same register removes two
    wr(4'd4); tick();
    wr(4'd4); tick();
    flush = 1'b1; wb(4'd4); tick();
    #1; check("r4_dec2", pending_mask, 16'h0000); check("r4_no_error", wb_error, 1'b0);

    // saturation at 3: four writes, three writebacks drain it
    for (int i = 0; i < 4; i++) begin wr(4'd6); tick(); end
    wb(4'd6); tick();
    wb(4'd6); tick();
    #1; check("r6_sat_still", pending_mask, 16'h0040);
    wb(4'd6); tick();
    #1; check("r6_sat_drained", pending_mask, 16'h0000); check("r6_no_error", wb_error, 1'b0);

    // writeback with nothing pending is sticky until reset
    wb(4'd9); tick();
    #1; check("r9_error", wb_error, 1'b1); check("r9_mask", pending_mask, 16'h0000);
    tick(); tick();
    #1; check("r9_error_sticky", wb_error, 1'b1);

    // reset in the middle of a stall
    wr(4'd1); tick();
    rd(4'd1); tick();
    rd(4'd1); tick();
    rd(4'd1); rst = 1'b1; #1; check("rst_mid_stall_on", stall, 1'b1); tick();
    rst = 1'b0; rd(4'd1); #1;
    check("rst_mid_stall", stall, 1'b0);
    check("rst_mid_mask", pending_mask, 16'h0000);
    check("rst_mid_count", stall_count, 16'h0000);
    check("rst_mid_error", wb_error, 1'b0);
    check("rst_mid_accept", issue_accept, 1'b1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have these parameters: NREGS, default 16, register count (index 15 = flag register); CW, default 2, per-register pending-counter width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port issue_valid, input, 1, OF stage presents an instruction this cycle.
REQ-005 SHALL have port issue_writes, input, 1, the presented instruction writes a destination register.
REQ-006 SHALL have port issue_dest, input, 4, destination register index.
REQ-007 SHALL have ports use_src1 and use_src2, input, 1 each, source operand enables.
REQ-008 SHALL have ports src1 and src2, input, 4 each, source register indices.
REQ-009 SHALL have port use_flags, input, 1, instruction reads register 15 (conditional branch).
REQ-010 SHALL have port wb_valid, input, 1, writeback stage commits a register write this cycle.
REQ-011 SHALL have port wb_dest, input, 4, committed register index.
REQ-012 SHALL have port flush, input, 1, taken-branch squash from EX.
REQ-013 SHALL have port stall, output, 1, hold the IF/OF latch and insert a bubble into OF/EX.
REQ-014 SHALL have port issue_accept, output, 1, the presented instruction entered EX this cycle.
REQ-015 SHALL have port pending_mask, output, 16, bit r set when counter[r] is non-zero.
REQ-016 SHALL have port stall_count, output, 16, count of stalled cycles.
REQ-017 SHALL have port wb_error, output, 1, sticky flag: writeback to a register with no pending write.

Function
REQ-018 Counters: one CW-bit pending counter per register; increment on accepted write-issue, decrement on wb_valid to that register.
REQ-019 stall (combinational) = issue_valid & ~flush & any enabled source (src1, src2, or register 15 if use_flags) with counter != 0; no bypass, so a same-cycle writeback does not clear the stall.
REQ-020 issue_accept = issue_valid & ~stall & ~flush.
REQ-021 A shadow EX tag (valid, dest) SHALL load {issue_accept & issue_writes, issue_dest} every cycle.
REQ-022 On flush, the shadow tag entry, if valid, SHALL be squashed: its counter decrements and the tag clears; an issue in the same cycle is dropped.
REQ-023 Simultaneous increment and decrement on the same register SHALL leave the counter unchanged; simultaneous squash and writeback to the same register SHALL decrement by 2.
REQ-024 A counter SHALL saturate at 2^CW-1 and SHALL not wrap below 0; decrementing a zero counter sets wb_error and leaves the counter at 0.
REQ-025 stall_count SHALL increment each cycle stall=1 and saturate at 16'hFFFF.
REQ-026 Latency: a counter change is visible on stall and pending_mask in the cycle after the causing edge.

Reset
REQ-027 While rst=1 at a clock edge, all counters, the shadow tag, stall_count and wb_error SHALL clear to 0; reset mid-stall SHALL drop every in-flight pending entry.
REQ-028 After reset: stall=0, pending_mask=0, and issue_accept follows issue_valid.

Structure
REQ-029 NREGS, the flag-register index 15 and the opcode-class constants SHALL live in the shared package pipe_pkg.
REQ-030 One sub-module, sb_counter (a single saturating up/down pending counter), SHALL be instantiated NREGS times.

Verification
REQ-031 Issue a write to R3, then the next cycle issue a read of R3 -> stall=1 for 3 cycles, then issue_accept=1 in the cycle after wb_valid with wb_dest=3.
REQ-032 Two back-to-back writes to R5, then one wb to R5 -> pending_mask[5] stays 1; the second wb -> 0.
REQ-033 Issue a write to R7, then flush on the next cycle -> counter[7] returns to 0 and a later read of R7 does not stall.
REQ-034 A write to R15 followed by a use_flags instruction -> stall until wb_dest=15 commits.
REQ-035 wb_valid to R9 with nothing pending -> wb_error=1 and it stays 1 until rst.
REQ-036 Assert rst during a 3-cycle stall -> the next cycle shows stall=0, pending_mask=0, stall_count=0.
